// File: rtl/mac_stop_seq_if.sv
// Memory-side bus between the matrix multiply sequencer and the mac_stop_mem banks.
// The sequencer is the master: it issues A/B reads and C writes; the memory returns read data.
interface mac_stop_seq_if #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) ();
  logic                                matrix_a_re;
  logic                                matrix_b_re;
  logic [$clog2(M)-1:0]                row_addr_a;
  logic [$clog2(K)-1:0]                col_addr_a;
  logic [$clog2(K)-1:0]                row_addr_b;
  logic [$clog2(N)-1:0]                col_addr_b;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b;
  logic                                matrix_c_we;
  logic [$clog2(M)-1:0]                row_addr_c;
  logic [$clog2(N)-1:0]                col_addr_c;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c;

  modport master (
    output matrix_a_re, matrix_b_re, row_addr_a, col_addr_a, row_addr_b, col_addr_b,
    output matrix_c_we, row_addr_c, col_addr_c, data_in_c,
    input  data_out_a, data_out_b
  );

  modport slave (
    input  matrix_a_re, matrix_b_re, row_addr_a, col_addr_a, row_addr_b, col_addr_b,
    input  matrix_c_we, row_addr_c, col_addr_c, data_in_c,
    output data_out_a, data_out_b
  );
endinterface

// File: rtl/mac_stop_seq.sv
// Sequencer computing C = A x B over the mac_stop_mem banks: K read cycles, one drain
// cycle and one write cycle per C element, walked in row-major order.
module mac_stop_seq #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  mac_stop_seq_if.master  mem
);
  localparam int AM = $clog2(M);
  localparam int AK = $clog2(K);
  localparam int AN = $clog2(N);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int RW = DATA_WIDTH_RESULT_MATRIX;

  localparam logic [AM-1:0] I_LAST = AM'(M-1);
  localparam logic [AK-1:0] K_LAST = AK'(K-1);
  localparam logic [AN-1:0] J_LAST = AN'(N-1);
  localparam logic [AM-1:0] I_ONE  = AM'(1);
  localparam logic [AK-1:0] K_ONE  = AK'(1);
  localparam logic [AN-1:0] J_ONE  = AN'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  logic [AM-1:0]   i_r;
  logic [AK-1:0]   k_r;
  logic [AN-1:0]   j_r;
  logic [RW-1:0]   acc_r;
  logic            busy_r;
  logic            done_r;
  logic [2*DW-1:0] prod_s;
  logic [RW-1:0]   acc_sum_s;

  // Read data always belongs to the read issued one cycle earlier.
  assign prod_s    = (2*DW)'(mem.data_out_a) * (2*DW)'(mem.data_out_b);
  assign acc_sum_s = acc_r + RW'(prod_s);
  assign busy      = busy_r;
  assign done      = done_r;

  // Control FSM; every output register holds the value for the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r         <= ST_IDLE;
      i_r             <= '0;
      k_r             <= '0;
      j_r             <= '0;
      acc_r           <= '0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      mem.matrix_a_re <= 1'b0;
      mem.matrix_b_re <= 1'b0;
      mem.row_addr_a  <= '0;
      mem.col_addr_a  <= '0;
      mem.row_addr_b  <= '0;
      mem.col_addr_b  <= '0;
      mem.matrix_c_we <= 1'b0;
      mem.row_addr_c  <= '0;
      mem.col_addr_c  <= '0;
      mem.data_in_c   <= '0;
    end else begin
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      mem.matrix_a_re <= 1'b0;
      mem.matrix_b_re <= 1'b0;
      mem.row_addr_a  <= '0;
      mem.col_addr_a  <= '0;
      mem.row_addr_b  <= '0;
      mem.col_addr_b  <= '0;
      mem.matrix_c_we <= 1'b0;
      mem.row_addr_c  <= '0;
      mem.col_addr_c  <= '0;
      mem.data_in_c   <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r         <= ST_RUN;
            i_r             <= '0;
            j_r             <= '0;
            k_r             <= '0;
            busy_r          <= 1'b1;
            mem.matrix_a_re <= 1'b1;
            mem.matrix_b_re <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Inner index 0 arrives while k_r is 1 and starts a fresh sum.
          if (k_r == K_ONE) begin
            acc_r <= RW'(prod_s);
          end else if (k_r != '0) begin
            acc_r <= acc_sum_s;
          end else begin
            acc_r <= acc_r;
          end
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (k_r == K_LAST) begin
            state_r <= ST_DRAIN;
            k_r     <= '0;
            busy_r  <= 1'b1;
          end else begin
            k_r             <= k_r + K_ONE;
            busy_r          <= 1'b1;
            mem.matrix_a_re <= 1'b1;
            mem.matrix_b_re <= 1'b1;
            mem.row_addr_a  <= i_r;
            mem.col_addr_a  <= k_r + K_ONE;
            mem.row_addr_b  <= k_r + K_ONE;
            mem.col_addr_b  <= j_r;
          end
        end
        ST_DRAIN: begin
          acc_r <= acc_sum_s;
          if (abort) begin
            state_r <= ST_IDLE;
          end else begin
            state_r         <= ST_WRITE;
            busy_r          <= 1'b1;
            mem.matrix_c_we <= 1'b1;
            mem.row_addr_c  <= i_r;
            mem.col_addr_c  <= j_r;
            mem.data_in_c   <= acc_sum_s;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state_r <= ST_IDLE;
          end else if ((i_r == I_LAST) && (j_r == J_LAST)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r         <= ST_RUN;
            busy_r          <= 1'b1;
            mem.matrix_a_re <= 1'b1;
            mem.matrix_b_re <= 1'b1;
            if (j_r == J_LAST) begin
              j_r            <= '0;
              i_r            <= i_r + I_ONE;
              mem.row_addr_a <= i_r + I_ONE;
              mem.col_addr_b <= '0;
            end else begin
              j_r            <= j_r + J_ONE;
              mem.row_addr_a <= i_r;
              mem.col_addr_b <= j_r + J_ONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_stop_seq.sv
// Directed-plus-random bench for mac_stop_seq: a registered-read memory model feeds the
// sequencer and every captured C write is compared against a plain dot-product reference.
module tb_mac_stop_seq;
  localparam int M  = 4;
  localparam int K  = 4;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 2*DW + $clog2(K);
  localparam int NCYC = 120;

  logic clk = 1'b0;
  logic resetn;
  logic start;
  logic abort;
  logic busy;
  logic done;

  mac_stop_seq_if #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW),
                    .DATA_WIDTH_RESULT_MATRIX(RW)) ifc ();

  mac_stop_seq #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW),
                 .DATA_WIDTH_RESULT_MATRIX(RW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem(ifc.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];

  // One-cycle registered read, as in mac_stop_mem.
  always @(posedge clk) begin
    if (ifc.matrix_a_re) ifc.data_out_a <= mem_a[ifc.row_addr_a][ifc.col_addr_a];
    if (ifc.matrix_b_re) ifc.data_out_b <= mem_b[ifc.row_addr_b][ifc.col_addr_b];
  end

  int            checks = 0;
  int            errors = 0;
  int            wr_cyc [$];
  int            wr_row [$];
  int            wr_col [$];
  logic [RW-1:0] wr_data [$];
  int            done_cyc [$];
  logic          busy_log [NCYC];
  int            en_late;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs_vec();
    return 128'({busy, done, ifc.matrix_a_re, ifc.matrix_b_re, ifc.matrix_c_we,
                 ifc.row_addr_a, ifc.col_addr_a, ifc.row_addr_b, ifc.col_addr_b,
                 ifc.row_addr_c, ifc.col_addr_c, ifc.data_in_c});
  endfunction

  function automatic logic [RW-1:0] ref_elem(input int i, input int j);
    logic [RW-1:0] s = '0;
    for (int k = 0; k < K; k++) s += RW'(mem_a[i][k]) * RW'(mem_b[k][j]);
    return s;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) mem_a[r][c] = $urandom();
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) mem_b[r][c] = $urandom();
  endtask

  // Runs one start (cycle 0) for NCYC cycles, logging outputs at each falling edge.
  task automatic do_run(input int restart_at, input int abort_at, input int reset_at);
    wr_cyc.delete(); wr_row.delete(); wr_col.delete(); wr_data.delete(); done_cyc.delete();
    en_late = 0;
    @(negedge clk);
    busy_log[0] = busy;
    start = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      busy_log[c] = busy;
      if (ifc.matrix_c_we) begin
        wr_cyc.push_back(c); wr_row.push_back(int'(ifc.row_addr_c));
        wr_col.push_back(int'(ifc.col_addr_c)); wr_data.push_back(ifc.data_in_c);
      end
      if (done) done_cyc.push_back(c);
      if (abort_at >= 0 && c > abort_at &&
          (ifc.matrix_a_re || ifc.matrix_b_re || ifc.matrix_c_we)) en_late++;
      start = (c == restart_at);
      abort = (c == abort_at);
      if (c == reset_at) begin
        resetn = 1'b0;
        #1;
        chk("async_rst_busy", 128'(busy), 128'd0);
        chk("async_rst_outs", outs_vec(), 128'd0);
      end
      if (reset_at >= 0 && c == reset_at + 2) resetn = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Writes with cycle <= cutoff must appear, in row-major order, each exactly once.
  task automatic check_results(input int cutoff, input bit full);
    int n_exp = 0;
    for (int idx = 0; idx < M*N; idx++) if ((idx + 1)*(K + 2) <= cutoff) n_exp++;
    chk("wr_count", 128'(wr_cyc.size()), 128'(n_exp));
    for (int w = 0; w < n_exp && w < wr_cyc.size(); w++) begin
      chk("wr_cycle", 128'(wr_cyc[w]), 128'((w + 1)*(K + 2)));
      chk("wr_row",   128'(wr_row[w]), 128'(w / N));
      chk("wr_col",   128'(wr_col[w]), 128'(w % N));
      chk("wr_data",  128'(wr_data[w]), 128'(ref_elem(w / N, w % N)));
    end
    if (full) begin
      chk("done_count", 128'(done_cyc.size()), 128'd1);
      chk("done_cycle", 128'(done_cyc[0]), 128'(M*N*(K + 2) + 1));
    end else begin
      chk("no_done", 128'(done_cyc.size()), 128'd0);
    end
  endtask

  initial begin
    int a_init [4][4] = '{'{4,3,2,5}, '{3,4,5,2}, '{5,2,4,3}, '{2,5,3,4}};
    int b_init [4][4] = '{'{7,6,5,8}, '{6,7,8,5}, '{8,5,7,6}, '{5,8,6,7}};
    logic [RW-1:0] wide_exp;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_outs", outs_vec(), 128'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Functional multiply and cycle accuracy with the reference matrices.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      mem_a[r][c] = DW'(a_init[r][c]);
      mem_b[r][c] = DW'(b_init[r][c]);
    end
    do_run(-1, -1, -1);
    check_results(100000, 1'b1);
    chk("busy_c0",   128'(busy_log[0]),  128'd0);
    chk("busy_c1",   128'(busy_log[1]),  128'd1);
    chk("busy_c97",  128'(busy_log[97]), 128'd0);
    chk("c00_value", 128'(wr_data[0]),   128'd87);
    chk("c00_cycle", 128'(wr_cyc[0]),    128'd6);
    chk("c33_value", 128'(wr_data[15]),  128'd87);
    chk("c33_cycle", 128'(wr_cyc[15]),   128'd96);
    chk("c12_value", 128'(wr_data[6]),   128'd94);

    // Start while busy is ignored; a later start in IDLE repeats the run.
    do_run(20, -1, -1);
    check_results(100000, 1'b1);
    do_run(-1, -1, -1);
    check_results(100000, 1'b1);

    // Width boundary: all-ones operands.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      mem_a[r][c] = '1;
      mem_b[r][c] = '1;
    end
    do_run(-1, -1, -1);
    check_results(100000, 1'b1);
    wide_exp = 66'h3_FFFF_FFF8_0000_0004;
    for (int w = 0; w < M*N; w++) chk("wide_elem", 128'(wr_data[w]), 128'(wide_exp));

    // Abort during RUN of element (0,2), then a clean run on the same data.
    fill_random();
    do_run(-1, 14, -1);
    check_results(14, 1'b0);
    chk("abort_enables", 128'(en_late), 128'd0);
    do_run(-1, -1, -1);
    check_results(100000, 1'b1);

    // Asynchronous reset in the middle of cycle 40, then a fresh random run.
    fill_random();
    do_run(-1, -1, 40);
    check_results(39, 1'b0);
    fill_random();
    do_run(-1, -1, -1);
    check_results(100000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_stop_seq.md
# mac_stop_seq

Sequencer for the `mac_stop_mem` matrix store. It runs C = A × B over the stored M×K matrix A and K×N matrix B, and writes every element of C back into the C bank. It drives the same read/write enables and row/column addresses that a host uses on `mac_stop_mem`, and holds the multiply-accumulate datapath internally. The host loads A and B, pulses `start`, waits for `done`, then reads C.

## Interface
- `M`, default 4: rows of A and C; must be ≥2.
- `K`, default 4: columns of A and rows of B; must be ≥2.
- `N`, default 4: columns of B and C; must be ≥2.
- `DATA_WIDTH_INIT_MATRIX`, default 32: element width of A and B (unsigned).
- `DATA_WIDTH_RESULT_MATRIX`, default 2*DATA_WIDTH_INIT_MATRIX+$clog2(K): element width of C.

- `clk` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: start request; sampled in IDLE only.
- `abort` in 1: synchronous abort of a running multiply.
- `busy` out 1: high in RUN, DRAIN and WRITE.
- `done` out 1: one-cycle pulse after the last C write.
- `matrix_a_re`, `matrix_b_re` out 1: read enables to the A and B banks.
- `row_addr_a` out $clog2(M): A row address.
- `col_addr_a` out $clog2(K): A column address.
- `row_addr_b` out $clog2(K): B row address.
- `col_addr_b` out $clog2(N): B column address.
- `data_out_a`, `data_out_b` in DATA_WIDTH_INIT_MATRIX: read data from memory, valid one cycle after the matching read enable.
- `matrix_c_we` out 1: write enable to the C bank.
- `row_addr_c` out $clog2(M): C row address.
- `col_addr_c` out $clog2(N): C column address.
- `data_in_c` out DATA_WIDTH_RESULT_MATRIX: write data for C.

## Operation
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE. Counters: i (C row), j (C column), k (inner index).
- **IDLE**:
  - `start`=1 → RUN, with i=j=k=0.
  - Otherwise stay in IDLE.
- **RUN** (K cycles per C element):
  - Assert `matrix_a_re` and `matrix_b_re`.
  - Drive row_addr_a=i, col_addr_a=k, row_addr_b=k, col_addr_b=j.
  - k increments each cycle; when k=K-1, go to DRAIN and clear k to 0.
- **Accumulate**: in every cycle after a read issue (RUN cycles with k≥1, plus DRAIN), compute the product p = data_out_a*data_out_b, a 2W-bit unsigned value.
  - The product of inner index 0 loads the accumulator: acc ← p.
  - Later products add: acc ← acc + p.
  - acc is DATA_WIDTH_RESULT_MATRIX wide, so it cannot overflow.
- **DRAIN** (1 cycle): no read enables; the last product is accumulated; next state WRITE.
- **WRITE** (1 cycle):
  - Assert `matrix_c_we` with row_addr_c=i, col_addr_c=j, data_in_c=acc.
  - If i=M-1 and j=N-1, go to DONE.
  - Otherwise advance in row-major order (j+1; at j=N-1, j←0 and i+1) and go to RUN.
- **DONE** (1 cycle): `done`=1, `busy`=0, next state IDLE.
- `start` is ignored outside IDLE.
- `abort`=1 in RUN, DRAIN or WRITE:
  - Go to IDLE at the next edge; no further reads or writes; `done` is not pulsed.
  - C elements already written stay written.
  - If `abort` is high in the same cycle as the WRITE state, that write still happens, because the enable is already asserted in that cycle.
- `abort` in IDLE or DONE has no effect.
- When not in their active state, all enables are 0, and addresses and `data_in_c` are 0.

## Timing
- Reset (asynchronous, `resetn` low):
  - State IDLE; i, j, k and acc cleared.
  - `busy`, `done`, `matrix_a_re`, `matrix_b_re`, `matrix_c_we` = 0; all address outputs and `data_in_c` = 0.
- Reset asserted mid-operation aborts immediately with the same values.
- Let cycle 0 be the cycle in which `start` is sampled high in IDLE:
  - Cycle 1: first RUN cycle; `busy`=1.
  - Each C element takes K+2 cycles: K in RUN, 1 in DRAIN, 1 in WRITE.
  - The write of element (i,j) happens in cycle (i*N+j+1)*(K+2).
  - `done`=1 in cycle M*N*(K+2)+1, which is 97 for 4×4×4.
- Memory read latency is exactly 1 cycle (registered read). The controller does not stall.
- All outputs are registered or decoded directly from state and counters; there are no combinational paths from input to output.

## Test plan
- **Functional multiply**: the bench memory model holds A={{4,3,2,5},{3,4,5,2},{5,2,4,3},{2,5,3,4}} and B={{7,6,5,8},{6,7,8,5},{8,5,7,6},{5,8,6,7}}; pulse `start`.
  - Required: C={{87,95,88,94},{95,87,94,88},{94,88,87,95},{88,94,95,87}}.
  - Required: 16 writes, each exactly once, in row-major order.
  - Required: `done` pulse in cycle 97.
- **Cycle accuracy**: same run; check each WRITE cycle index and address.
  - Required: C[0][0]=87 written in cycle 6, C[3][3]=87 in cycle 96.
  - Required: `busy` low in cycles 0 and 97.
- **Width boundary**: all A and B elements 0xFFFFFFFF.
  - Required: every C element = 4*(2^32-1)^2 = 0x3_FFFF_FFF8_0000_0004, with no truncation.
- **Start while busy**: pulse `start` again in cycle 20.
  - Required: no restart, order unchanged, a single `done` in cycle 97.
  - Then pulse `start` in IDLE. Required: a second full run with identical results.
- **Abort**: assert `abort` in cycle 14, during the RUN of element (0,2).
  - Required: writes in cycles 6 and 12 only; from cycle 15 all enables are 0; no `done`.
  - Then run a fresh `start`. Required: correct results, with acc not polluted by the aborted run.
- **Async reset mid-run**: drop `resetn` in the middle of cycle 40.
  - Required: outputs are 0 immediately, before the next edge.
  - After release: IDLE; a new `start` produces correct C.
